// File: rtl/cgra_im_loader_pkg.sv
// Shared types and header field layout for the CGRA instruction-memory loader.
package cgra_im_loader_pkg;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_ID,
        ST_IMM_LO,
        ST_IMM_HI,
        ST_DONE
    } state_e;

    // Header word: [31:24] target, [23:12] instruction count, [11:0] start address
    localparam int TGT_LSB    = 24;
    localparam int TGT_W      = 8;
    localparam int CNT_LSB    = 12;
    localparam int CNT_W      = 12;
    localparam int ADDR_W_MAX = 12;

endpackage

// File: rtl/cgra_im_loader_if.sv
// Stream input, IM write port and host status signals of the loader.
// Optional macro CGRA_IM_LOADER_CHECKSUM_EN adds the oChecksum status output.
interface cgra_im_loader_if #(
    parameter int IN_WIDTH          = 32,
    parameter int I_WIDTH           = 12,
    parameter int I_IMM_WIDTH       = 33,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_ID            = 10,
    parameter int NUM_IMM           = 3
);
    logic                           iInValid;
    logic [IN_WIDTH-1:0]            iInData;
    logic                           oInReady;
    logic [NUM_IMM+NUM_ID-1:0]      oIM_WriteEnable;
    logic [IM_MEM_ADDR_WIDTH-1:0]   oIM_WriteAddress;
    logic [I_WIDTH-1:0]             oIM_WriteData;
    logic [I_IMM_WIDTH-1:0]         oIM_WriteData_IMM;
    logic                           oBusy;
    logic                           oDone;
    logic                           oError;
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
    logic [31:0]                    oChecksum;
`endif

    // Loader side: consumes the stream, drives the IM port and status
    modport master (
        input  iInValid, iInData,
        output oInReady, oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData,
        output oIM_WriteData_IMM, oBusy, oDone, oError
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
        , output oChecksum
`endif
    );

    // Host / memory side
    modport slave (
        output iInValid, iInData,
        input  oInReady, oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData,
        input  oIM_WriteData_IMM, oBusy, oDone, oError
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
        , input oChecksum
`endif
    );
endinterface

// File: rtl/cgra_im_loader_hdr_decode.sv
// Combinational header split and target classification (ID / IMM / bad).
module cgra_im_loader_hdr_decode
    import cgra_im_loader_pkg::*;
#(
    parameter int IN_WIDTH          = 32,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_ID            = 10,
    parameter int NUM_IMM           = 3
) (
    input  logic [IN_WIDTH-1:0]          hdr,
    output logic [TGT_W-1:0]             tgt,
    output logic [CNT_W-1:0]             cnt,
    output logic [IM_MEM_ADDR_WIDTH-1:0] addr,
    output logic                         is_id,
    output logic                         is_imm,
    output logic                         bad
);
    // One extra bit so NUM_ID+NUM_IMM up to 256 still compares correctly
    localparam int LIM_W = TGT_W + 1;
    localparam logic [LIM_W-1:0] ID_END  = LIM_W'(NUM_ID);
    localparam logic [LIM_W-1:0] IMM_END = LIM_W'(NUM_ID + NUM_IMM);

    logic [ADDR_W_MAX-1:0] addr_field;

    assign tgt        = hdr[TGT_LSB +: TGT_W];
    assign cnt        = hdr[CNT_LSB +: CNT_W];
    assign addr_field = hdr[0 +: ADDR_W_MAX];
    // Address bits above the memory width are ignored
    assign addr       = addr_field[IM_MEM_ADDR_WIDTH-1:0];

    assign is_id  = ({1'b0, tgt} < ID_END);
    assign is_imm = !is_id && ({1'b0, tgt} < IMM_END);
    assign bad    = !is_id && !is_imm;

    if (IM_MEM_ADDR_WIDTH < ADDR_W_MAX) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_field[ADDR_W_MAX-1:IM_MEM_ADDR_WIDTH];
    end
endmodule

// File: rtl/cgra_im_loader.sv
// CGRA instruction-memory loader: parses header + payload stream and issues
// one-cycle registered writes on the shared IM write port.
// Optional macro CGRA_IM_LOADER_CHECKSUM_EN adds a running oChecksum output.
module cgra_im_loader
    import cgra_im_loader_pkg::*;
#(
    parameter int IN_WIDTH          = 32,
    parameter int I_WIDTH           = 12,
    parameter int I_IMM_WIDTH       = 33,
    parameter int IM_MEM_ADDR_WIDTH = 8,
    parameter int NUM_ID            = 10,
    parameter int NUM_IMM           = 3
) (
    input  logic              iClk,
    input  logic              iReset,
    cgra_im_loader_if.master  bus
);
    localparam int NUM_MEM = NUM_ID + NUM_IMM;
    localparam int HI_W    = I_IMM_WIDTH - IN_WIDTH;

    state_e                         state_q, state_d;
    logic [TGT_W-1:0]               tgt_q, tgt_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IM_MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IN_WIDTH-1:0]            lo_q, lo_d;
    logic                           err_q, err_d;
    logic [NUM_MEM-1:0]             we_q, we_d;
    logic [IM_MEM_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [I_WIDTH-1:0]             wr_data_q, wr_data_d;
    logic [I_IMM_WIDTH-1:0]         wr_imm_q, wr_imm_d;

    logic                           accept;
    logic                           issue;
    logic [I_WIDTH-1:0]             id_word;
    logic [I_IMM_WIDTH-1:0]         imm_word;

    logic [TGT_W-1:0]               hd_tgt;
    logic [CNT_W-1:0]               hd_cnt;
    logic [IM_MEM_ADDR_WIDTH-1:0]   hd_addr;
    logic                           hd_is_id, hd_is_imm, hd_bad;

    cgra_im_loader_hdr_decode #(
        .IN_WIDTH          (IN_WIDTH),
        .IM_MEM_ADDR_WIDTH (IM_MEM_ADDR_WIDTH),
        .NUM_ID            (NUM_ID),
        .NUM_IMM           (NUM_IMM)
    ) u_hdr_decode (
        .hdr    (bus.iInData),
        .tgt    (hd_tgt),
        .cnt    (hd_cnt),
        .addr   (hd_addr),
        .is_id  (hd_is_id),
        .is_imm (hd_is_imm),
        .bad    (hd_bad)
    );

    // The write port never stalls, so only the one-cycle done state refuses data
    assign accept = bus.iInValid && (state_q != ST_DONE);

    // Next-state, block bookkeeping and write-issue decode
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        err_d     = err_q;
        we_d      = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = '0;
        wr_imm_d  = '0;
        issue     = 1'b0;
        id_word   = '0;
        imm_word  = '0;

        case (state_q)
            ST_HEADER: begin
                if (accept) begin
                    tgt_d  = hd_tgt;
                    cnt_d  = hd_cnt;
                    addr_d = hd_addr;
                    err_d  = hd_bad;
                    lo_d   = '0;
                    // Bad targets run as ID blocks so the payload is still consumed
                    if (hd_cnt == '0)              state_d = ST_DONE;
                    else if (hd_is_id || hd_bad)   state_d = ST_ID;
                    else if (hd_is_imm)            state_d = ST_IMM_LO;
                end
            end
            ST_ID: begin
                if (accept) begin
                    issue   = 1'b1;
                    id_word = bus.iInData[I_WIDTH-1:0];
                end
            end
            ST_IMM_LO: begin
                if (accept) begin
                    lo_d    = bus.iInData;
                    state_d = ST_IMM_HI;
                end
            end
            ST_IMM_HI: begin
                if (accept) begin
                    issue    = 1'b1;
                    imm_word = {bus.iInData[HI_W-1:0], lo_q};
                    state_d  = ST_IMM_LO;
                end
            end
            ST_DONE:  state_d = ST_HEADER;
            default:  state_d = ST_HEADER;
        endcase

        if (issue) begin
            cnt_d  = cnt_q - 1'b1;
            addr_d = addr_q + 1'b1;
            lo_d   = '0;
            if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            // Discarded (bad-target) instructions leave the port idle
            if (!err_q) begin
                wr_addr_d = addr_q;
                wr_data_d = id_word;
                wr_imm_d  = imm_word;
                for (int i = 0; i < NUM_MEM; i++) begin
                    we_d[i] = (tgt_q == TGT_W'(i));
                end
            end
        end
    end

    // State and registered write-port outputs; reset aborts any partial block
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q   <= ST_HEADER;
            tgt_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            lo_q      <= '0;
            err_q     <= 1'b0;
            we_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_imm_q  <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            err_q     <= err_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_imm_q  <= wr_imm_d;
        end
    end

    assign bus.oInReady          = (state_q != ST_DONE);
    assign bus.oBusy             = (state_q != ST_HEADER);
    assign bus.oDone             = (state_q == ST_DONE);
    assign bus.oError            = err_q;
    assign bus.oIM_WriteEnable   = we_q;
    assign bus.oIM_WriteAddress  = wr_addr_q;
    assign bus.oIM_WriteData     = wr_data_q;
    assign bus.oIM_WriteData_IMM = wr_imm_q;

`ifdef CGRA_IM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    // Running checksum of issued instructions; IMM words fold in their low 32 bits
    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_HEADER) && accept) begin
            csum_d = '0;
        end else if (issue && !err_q) begin
            csum_d = {csum_q[30:0], csum_q[31]} ^ 32'(id_word) ^ 32'(imm_word);
        end
    end

    // Checksum register
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign bus.oChecksum = csum_q;
`endif
endmodule

// File: tb/tb_cgra_im_loader.sv
// Self-checking bench for cgra_im_loader: directed test-plan blocks plus
// randomized block streams, checked every cycle against a stream-parser model.
module tb_cgra_im_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cgra_im_loader_if ifc ();

    cgra_im_loader dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (ifc)
    );

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: a plain stream parser ----------------
    bit          m_ready, m_busy, m_done, m_err;
    int          m_we;            // target strobed this cycle, -1 if none
    int          m_wr_addr;
    logic [63:0] m_ins;
    logic [31:0] m_csum;
    bit          p_hdr, p_imm, p_bad, p_half;
    int          p_tgt, p_left, p_addr;
    logic [31:0] p_lo, w;
    bit          nd;
    int          nwe;
    logic [63:0] ins;

    function automatic logic [31:0] rotl1(input logic [31:0] c);
        return {c[30:0], c[31]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1; m_busy = 0; m_done = 0; m_err = 0; m_we = -1;
            m_wr_addr = 0; m_ins = '0; m_csum = '0;
            p_hdr = 1; p_imm = 0; p_bad = 0; p_half = 0; p_left = 0; p_addr = 0; p_lo = '0;
        end else begin
            w = ifc.iInData;
            nd = 0; nwe = -1;
            if (m_done) begin
                m_busy = 0;
            end else if (ifc.iInValid && m_ready) begin
                if (p_hdr) begin
                    p_tgt  = int'(w[31:24]);
                    p_left = int'(w[23:12]);
                    p_addr = int'(w[7:0]);
                    p_bad  = (p_tgt >= 13);
                    p_imm  = (p_tgt >= 10) && !p_bad;
                    p_half = 0;
                    m_err  = p_bad; m_busy = 1; m_csum = '0;
                    if (p_left == 0) nd = 1; else p_hdr = 0;
                end else if (p_imm && !p_half) begin
                    p_lo = w; p_half = 1;
                end else begin
                    ins = p_imm ? {31'b0, w[0], p_lo} : {52'b0, w[11:0]};
                    if (!p_bad) begin
                        nwe = p_tgt; m_wr_addr = p_addr; m_ins = ins;
                        m_csum = rotl1(m_csum) ^ ins[31:0];
                    end
                    p_addr = (p_addr + 1) % 256;
                    p_left--; p_half = 0;
                    if (p_left == 0) begin nd = 1; p_hdr = 1; end
                end
            end
            m_done = nd; m_ready = !nd; m_we = nwe;
        end
    end

    // ---------------- compare process + observed write log ----------------
    int          log_tgt[$];
    int          log_addr[$];
    logic [63:0] log_data[$];
    bit          log_done[$];
    logic [12:0] exp_we;
    logic [11:0] exp_id;
    logic [32:0] exp_imm;
    int          t;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_we = '0; exp_id = '0; exp_imm = '0;
            if (m_we >= 0) begin
                exp_we[m_we] = 1'b1;
                if (m_we < 10) exp_id = m_ins[11:0]; else exp_imm = m_ins[32:0];
            end
            chk("we", 64'(ifc.oIM_WriteEnable), 64'(exp_we));
            chk("ready/busy/done/err", 64'({ifc.oInReady, ifc.oBusy, ifc.oDone, ifc.oError}),
                64'({m_ready, m_busy, m_done, m_err}));
            chk("id_data", 64'(ifc.oIM_WriteData), 64'(exp_id));
            chk("imm_data", 64'(ifc.oIM_WriteData_IMM), 64'(exp_imm));
            if (m_we >= 0) chk("addr", 64'(ifc.oIM_WriteAddress), 64'(m_wr_addr));
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
            if (m_done) chk("checksum", 64'(ifc.oChecksum), 64'(m_csum));
`endif
            if (ifc.oIM_WriteEnable != '0) begin
                t = -1;
                for (int i = 0; i < 13; i++) if (ifc.oIM_WriteEnable[i]) t = i;
                log_tgt.push_back(t);
                log_addr.push_back(int'(ifc.oIM_WriteAddress));
                log_data.push_back((t < 10) ? 64'(ifc.oIM_WriteData) : 64'(ifc.oIM_WriteData_IMM));
                log_done.push_back(ifc.oDone);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_log();
        log_tgt.delete(); log_addr.delete(); log_data.delete(); log_done.delete();
    endtask

    // Called at a negedge; returns at the negedge right after the word is accepted
    task automatic send(input logic [31:0] word, input int gap);
        int k;
        for (int g = 0; g < gap; g++) begin
            ifc.iInValid = 1'b0; ifc.iInData = $urandom;
            @(negedge clk);
        end
        ifc.iInValid = 1'b1; ifc.iInData = word;
        k = 0;
        while (!ifc.oInReady && k < 10) begin @(negedge clk); k++; end
        if (k == 10) chk("ready_timeout", 64'(0), 64'(1));
        @(negedge clk);
        ifc.iInValid = 1'b0;
    endtask

    task automatic chk_write(input string name, input int idx, input int tg, input int ad,
                             input logic [63:0] dat);
        if (log_tgt.size() > idx) begin
            chk({name, "_tgt"},  64'(log_tgt[idx]),  64'(tg));
            chk({name, "_addr"}, 64'(log_addr[idx]), 64'(ad));
            chk({name, "_data"}, log_data[idx], dat);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ifc.iInValid = 1'b0;
        ifc.iInData  = '0;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_ready", 64'(ifc.oInReady), 64'(1));
        chk("rst_outs", 64'({ifc.oBusy, ifc.oDone, ifc.oError, ifc.oIM_WriteEnable}), 64'(0));
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // ID block: target 3, N=3, addr 0x10
        clear_log();
        send(32'h03_003_010, 0); send(32'h0000_0ABC, 0); send(32'hFFFF_F123, 1); send(32'h0000_0FFF, 0);
        chk("id_done_with_last", 64'(ifc.oDone), 64'(1));
        repeat (2) @(negedge clk);
        chk("id_nwrites", 64'(log_tgt.size()), 64'(3));
        chk_write("id0", 0, 3, 8'h10, 64'hABC);
        chk_write("id1", 1, 3, 8'h11, 64'h123);
        chk_write("id2", 2, 3, 8'h12, 64'hFFF);
        if (log_done.size() == 3) chk("id_done_flag", 64'({log_done[0], log_done[1], log_done[2]}), 64'(3'b001));

        // IMM block: target 11, N=1, addr 0x05
        clear_log();
        send(32'h0B_001_005, 0); send(32'hDEAD_BEEF, 0); send(32'h0000_0001, 0);
        repeat (2) @(negedge clk);
        chk("imm_nwrites", 64'(log_tgt.size()), 64'(1));
        chk_write("imm0", 0, 11, 8'h05, 64'h1_DEAD_BEEF);

        // Address wrap: target 0, N=2, addr 0xFF
        clear_log();
        send(32'h00_002_0FF, 0); send(32'h0000_0007, 0); send(32'h0000_0009, 2);
        repeat (2) @(negedge clk);
        chk_write("wrap0", 0, 0, 8'hFF, 64'h7);
        chk_write("wrap1", 1, 0, 8'h00, 64'h9);

        // Bad target then a good block
        clear_log();
        send(32'h20_002_000, 0); send(32'h0000_0001, 0); send(32'h0000_0002, 0);
        repeat (2) @(negedge clk);
        chk("bad_err", 64'(ifc.oError), 64'(1));
        chk("bad_nwrites", 64'(log_tgt.size()), 64'(0));
        send(32'h01_001_030, 1);
        chk("bad_err_cleared", 64'(ifc.oError), 64'(0));
        send(32'h0000_0055, 0);
        repeat (2) @(negedge clk);
        chk_write("after_bad", 0, 1, 8'h30, 64'h55);

        // N=0 header
        clear_log();
        send(32'h02_000_044, 0);
        chk("n0_done_ready", 64'({ifc.oDone, ifc.oInReady, ifc.oBusy}), 64'(3'b101));
        @(negedge clk);
        chk("n0_after", 64'({ifc.oDone, ifc.oInReady, ifc.oBusy}), 64'(3'b010));
        chk("n0_nwrites", 64'(log_tgt.size()), 64'(0));

        // Reset after IMM low word
        clear_log();
        send(32'h0A_001_000, 0); send(32'h1234_5678, 0);
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_busy", 64'(ifc.oBusy), 64'(0));
`ifdef CGRA_IM_LOADER_CHECKSUM_EN
        chk("rst_mid_csum", 64'(ifc.oChecksum), 64'(0));
`endif
        send(32'h00_001_040, 0); send(32'h0000_0077, 0);
        repeat (2) @(negedge clk);
        chk("rst_mid_nwrites", 64'(log_tgt.size()), 64'(1));
        chk_write("rst_mid_next", 0, 0, 8'h40, 64'h77);

        // Randomized block streams, checked cycle by cycle against the model
        for (int b = 0; b < 60; b++) begin
            int r, tg, n, words;
            r  = $urandom_range(0, 15);
            tg = (r == 15) ? int'($urandom_range(16, 255)) : r;
            n  = $urandom_range(0, 4);
            send({8'(tg), 12'(n), 12'($urandom)}, $urandom_range(0, 2));
            words = (tg >= 10 && tg < 13) ? 2 * n : n;
            for (int i = 0; i < words; i++) send($urandom, $urandom_range(0, 2));
        end
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cgra_im_loader.md
Name: cgra_im_loader

Overview:
- Write-side master for the CGRA instruction memories.
- Accepts a valid/ready stream of 32-bit words from the host or DMA, parses a header per block, and packs the payload into instructions.
- Drives the shared IM write port (one-hot write enable, shared address, shared ID data, shared IMM data) of the CGRA memory wrapper.
- Signals busy/done/error to the host controller; the CGRA is held in reset while oBusy=1.

Parameters:
IN_WIDTH, 32, input stream word width
I_WIDTH, 12, ID instruction width; must be ≤ IN_WIDTH
I_IMM_WIDTH, 33, IMM instruction width; IN_WIDTH < I_IMM_WIDTH ≤ 2*IN_WIDTH
IM_MEM_ADDR_WIDTH, 8, IM address width; must be ≤ 12
NUM_ID, 10, number of ID memories (targets 0..NUM_ID-1)
NUM_IMM, 3, number of IMM memories (targets NUM_ID..NUM_ID+NUM_IMM-1)

Ports:
iClk  in  1  clock
iReset  in  1  asynchronous active-high reset
iInValid  in  1  stream word valid
iInData  in  IN_WIDTH  stream word
oInReady  out  1  stream ready; word accepted when iInValid&&oInReady
oIM_WriteEnable  out  NUM_IMM+NUM_ID  one-hot write strobe
oIM_WriteAddress  out  IM_MEM_ADDR_WIDTH  shared write address
oIM_WriteData  out  I_WIDTH  ID instruction data
oIM_WriteData_IMM  out  I_IMM_WIDTH  IMM instruction data
oBusy  out  1  high from header accept until the block is done
oDone  out  1  one-cycle pulse at block end
oError  out  1  sticky bad-target flag; cleared by the next header accept

Behaviour:
- Reset: all outputs 0 except oInReady=1. State returns to ST_HEADER.
- Header word layout:
  - [31:24] target index
  - [23:12] instruction count N
  - [11:0] start address; bits above IM_MEM_ADDR_WIDTH are ignored
- FSM states: ST_HEADER, ST_ID, ST_IMM_LO, ST_IMM_HI, ST_DONE.
- ST_HEADER, on accept:
  - Latch target, count and address; set oBusy=1; clear oError.
  - N=0 -> ST_DONE.
  - target < NUM_ID -> ST_ID.
  - NUM_ID ≤ target < NUM_ID+NUM_IMM -> ST_IMM_LO.
  - Otherwise: oError=1, treat as an ID block, and force all write strobes to 0 (payload is consumed and discarded, so the stream stays aligned).
- ST_ID: each accepted word is one instruction using iInData[I_WIDTH-1:0].
- ST_IMM_LO: accept the low word into a holding register, then -> ST_IMM_HI.
- ST_IMM_HI: the instruction is {iInData[I_IMM_WIDTH-IN_WIDTH-1:0], lo}. Return to ST_IMM_LO, or go to ST_DONE when the count is exhausted.
- Write issue timing:
  - Registered; the strobe rises the cycle after the completing word is accepted and lasts exactly 1 cycle.
  - Only bit[target] is set.
  - Address and data are stable during the strobe.
  - Unused data bus (ID vs IMM) is held at 0.
- Address: increments by 1 after each write and wraps modulo 2^IM_MEM_ADDR_WIDTH (255 -> 0 at the default width).
- Counter: decrements once per completed instruction. The last instruction moves the FSM to ST_DONE.
- ST_DONE: lasts one cycle, during which oInReady=0. It pulses oDone, which coincides with the last write strobe (or with the cycle after header accept when N=0). Next state is ST_HEADER and oBusy drops.
- oInReady=1 in every state except ST_DONE; the memory write port never stalls.
- iReset asserted mid-block:
  - Aborts immediately, with no partial instruction write.
  - The holding register and counter are cleared.
  - Memory contents already written are not altered.

Optional Feature:
- Macro: CGRA_IM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output oChecksum [31:0], which resets to 0 on each header accept.
  - Each issued write updates it as rotate-left-1(checksum) XOR the zero-extended instruction.
  - It is valid and stable from the oDone cycle until the next header accept.
  - Discarded (bad-target) data is not included.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package cgra_im_loader_pkg holds:
  - the state enum;
  - header field offsets/widths (TGT_LSB=24, CNT_LSB=12, CNT_W=12, ADDR_W_MAX=12).
- One sub-module, cgra_im_loader_hdr_decode: combinational header split plus target classification (is_id, is_imm, bad).

Test Plan:
- ID block: header 0x03_003_010 followed by words 0xABC, 0x123, 0xFFF -> three strobes on bit3 at addrs 0x10, 0x11, 0x12 with data 0xABC, 0x123, 0xFFF; oDone coincides with the third strobe.
- IMM block: target 11, N=1, addr 0x05, words 0xDEADBEEF then 0x1 -> one strobe on bit11, oIM_WriteData_IMM=0x1DEADBEEF, addr 0x05.
- Wrap: target 0, N=2, addr 0xFF -> writes at 0xFF then 0x00.
- Bad target 0x20, N=2, then a valid header -> no strobes; oError=1 until the next header is accepted; the next block writes correctly.
- N=0 header -> no strobe; oDone pulses one cycle after accept; the following header is accepted the cycle after that.
- Reset asserted after the IMM low word -> no strobe; oBusy=0; the next header starts clean (checksum build: oChecksum=0).
